// File: rtl/apb_reg_slave.sv
// APB register-file slave: reg 0 read-only ID, regs 1..NUM_REGS-1 read/write.
// Ports: HCLK/HRESETn, APB PSEL/PENABLE/PADDR/PWRITE/PWDATA in; PRDATA/PREADY/PSLVERR out.
// Optional feature: define APB_SLV_ERR_EN to report decode errors on PSLVERR.
module apb_reg_slave #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int NUM_REGS    = 16,
  parameter int WAIT_CYCLES = 0,
  parameter logic [DATA_WIDTH-1:0] ID_VALUE = 32'hA5B0_0001
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  PSEL,
  input  logic                  PENABLE,
  input  logic [ADDR_WIDTH-1:0] PADDR,
  input  logic                  PWRITE,
  input  logic [DATA_WIDTH-1:0] PWDATA,
  output logic [DATA_WIDTH-1:0] PRDATA,
  output logic                  PREADY,
  output logic                  PSLVERR
);

  localparam int IW = $clog2(NUM_REGS);

`ifdef APB_SLV_ERR_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t                state;
  logic [3:0]            cnt;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  wr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] regs [1:NUM_REGS-1];
  logic                  pready_q;
  logic                  perr_q;
  logic [DATA_WIDTH-1:0] prdata_q;

  logic                  setup_ph;
  logic                  access_ph;
  logic                  go_ready;
  logic [ADDR_WIDTH-1:0] d_addr;
  logic                  d_wr;
  logic [IW-1:0]         d_idx;
  logic                  d_err;
  logic [DATA_WIDTH-1:0] d_rdata;

  assign setup_ph  = PSEL & ~PENABLE;
  assign access_ph = PSEL & PENABLE;

  // Decode the live bus during setup (it is being captured that edge),
  // and the captured copy for the rest of the access.
  always_comb begin
    d_addr  = (state == IDLE) ? PADDR  : addr_q;
    d_wr    = (state == IDLE) ? PWRITE : wr_q;
    d_idx   = d_addr[IW+1:2];
    d_err   = (d_addr[1:0] != 2'b00)
            | (|d_addr[ADDR_WIDTH-1:IW+2])
            | (d_wr & (d_idx == '0));
    d_rdata = '0;
    if (!d_err) begin
      if (d_idx == '0) begin
        d_rdata = ID_VALUE;
      end else begin
        for (int i = 1; i < NUM_REGS; i++) begin
          if (d_idx == IW'(i)) d_rdata = regs[i];
        end
      end
    end
  end

  // Edge that enters the PREADY=1 cycle: load read data and error flag.
  always_comb begin
    go_ready = 1'b0;
    unique case (1'b1)
      (state == IDLE):
        go_ready = setup_ph & (WAIT_CYCLES == 0);
      (state == ACCESS):
        go_ready = access_ph & (cnt == 4'd1);
      default: go_ready = 1'b0;
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state    <= IDLE;
      cnt      <= '0;
      addr_q   <= '0;
      wr_q     <= 1'b0;
      wdata_q  <= '0;
      pready_q <= 1'b0;
      perr_q   <= 1'b0;
      prdata_q <= '0;
      for (int i = 1; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (setup_ph) begin
            state   <= ACCESS;
            addr_q  <= PADDR;
            wr_q    <= PWRITE;
            wdata_q <= PWDATA;
            cnt     <= 4'(WAIT_CYCLES);
          end
        end
        ACCESS: begin
          if (!access_ph) begin
            state    <= IDLE;
            cnt      <= '0;
            pready_q <= 1'b0;
            perr_q   <= 1'b0;
          end else if (pready_q) begin
            state    <= IDLE;
            pready_q <= 1'b0;
            perr_q   <= 1'b0;
            if (wr_q && !d_err) begin
              for (int i = 1; i < NUM_REGS; i++) begin
                if (d_idx == IW'(i)) regs[i] <= wdata_q;
              end
            end
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
      if (go_ready) begin
        pready_q <= 1'b1;
        perr_q   <= ERR_EN & d_err;
        if (!d_wr) prdata_q <= d_rdata;
      end
    end
  end

  assign PREADY  = pready_q;
  assign PSLVERR = perr_q;
  assign PRDATA  = prdata_q;

endmodule

// File: tb/tb_apb_reg_slave.sv
// Bench for apb_reg_slave: three instances (0, 3 and 2 wait states)
// on a shared APB bus, each with its own PSEL.
module tb_apb_reg_slave;

`ifdef APB_SLV_ERR_EN
  localparam bit E = 1'b1;
`else
  localparam bit E = 1'b0;
`endif

  localparam logic [31:0] ID = 32'hA5B0_0001;

  logic        HCLK = 1'b0;
  logic        HRESETn = 1'b0;
  logic [2:0]  psel = '0;
  logic        PENABLE = 1'b0;
  logic [31:0] PADDR = '0;
  logic        PWRITE = 1'b0;
  logic [31:0] PWDATA = '0;
  logic [31:0] prdata [3];
  logic        pready [3];
  logic        pslverr [3];

  int n_chk = 0;
  int n_fail = 0;

  always #5 HCLK = ~HCLK;

  apb_reg_slave #(.WAIT_CYCLES(0)) u0 (
    .HCLK(HCLK), .HRESETn(HRESETn), .PSEL(psel[0]), .PENABLE(PENABLE),
    .PADDR(PADDR), .PWRITE(PWRITE), .PWDATA(PWDATA),
    .PRDATA(prdata[0]), .PREADY(pready[0]), .PSLVERR(pslverr[0]));

  apb_reg_slave #(.WAIT_CYCLES(3)) u3 (
    .HCLK(HCLK), .HRESETn(HRESETn), .PSEL(psel[1]), .PENABLE(PENABLE),
    .PADDR(PADDR), .PWRITE(PWRITE), .PWDATA(PWDATA),
    .PRDATA(prdata[1]), .PREADY(pready[1]), .PSLVERR(pslverr[1]));

  apb_reg_slave #(.WAIT_CYCLES(2)) u2 (
    .HCLK(HCLK), .HRESETn(HRESETn), .PSEL(psel[2]), .PENABLE(PENABLE),
    .PADDR(PADDR), .PWRITE(PWRITE), .PWDATA(PWDATA),
    .PRDATA(prdata[2]), .PREADY(pready[2]), .PSLVERR(pslverr[2]));

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Starts right after a rising edge; leaves the bus one cycle after the
  // completing edge so calls chain back-to-back. Address/data/direction
  // are scrambled during access to show the captured copies are used.
  task automatic xfer(input int d, input bit wr, input logic [31:0] a,
                      input logic [31:0] wd, output logic [31:0] rd,
                      output bit er, output int w);
    bit done;
    psel = '0;
    psel[d] = 1'b1;
    PENABLE = 1'b0;
    PADDR = a;
    PWRITE = wr;
    PWDATA = wd;
    @(posedge HCLK); #1;
    PENABLE = 1'b1;
    PADDR = a ^ 32'h0000_0004;
    PWRITE = ~wr;
    PWDATA = ~wd;
    w = 0;
    done = 1'b0;
    while (!done) begin
      @(negedge HCLK);
      if (pready[d]) begin
        done = 1'b1;
      end else begin
        chk("pslverr_in_wait", 32'(pslverr[d]), 32'd0);
        w++;
        if (w > 40) begin
          n_chk++;
          n_fail++;
          $display("FAIL timeout: PREADY never rose on dut %0d", d);
          done = 1'b1;
        end else begin
          @(posedge HCLK); #1;
        end
      end
    end
    rd = prdata[d];
    er = pslverr[d];
    @(posedge HCLK); #1;
    psel = '0;
    PENABLE = 1'b0;
  endtask

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    bit          err;
  } vec_t;

  vec_t vt [14];

  initial begin
    logic [31:0] rd;
    bit er;
    int w;

    vt[0]  = '{0, 32'h00, 32'h0,         ID,            0};
    vt[1]  = '{1, 32'h04, 32'hDEADBEEF,  ID,            0};
    vt[2]  = '{0, 32'h04, 32'h0,         32'hDEADBEEF,  0};
    vt[3]  = '{0, 32'h08, 32'h0,         32'h0,         0};
    vt[4]  = '{1, 32'h40, 32'h11111111,  32'h0,         E};
    vt[5]  = '{1, 32'h06, 32'h22222222,  32'h0,         E};
    vt[6]  = '{1, 32'h00, 32'h33333333,  32'h0,         E};
    vt[7]  = '{0, 32'h40, 32'h0,         32'h0,         E};
    vt[8]  = '{0, 32'h04, 32'h0,         32'hDEADBEEF,  0};
    vt[9]  = '{0, 32'h00, 32'h0,         ID,            0};
    vt[10] = '{1, 32'h3C, 32'hA5A5A5A5,  ID,            0};
    vt[11] = '{0, 32'h3C, 32'h0,         32'hA5A5A5A5,  0};
    vt[12] = '{0, 32'h06, 32'h0,         32'h0,         E};
    vt[13] = '{0, 32'h1000_0000, 32'h0,  32'h0,         E};

    repeat (3) @(posedge HCLK);
    #1;
    for (int d = 0; d < 3; d++) begin
      chk("reset_pready", 32'(pready[d]), 32'd0);
      chk("reset_pslverr", 32'(pslverr[d]), 32'd0);
      chk("reset_prdata", prdata[d], 32'd0);
    end
    HRESETn = 1'b1;
    @(posedge HCLK); #1;

    for (int i = 0; i < 14; i++) begin
      xfer(0, vt[i].wr, vt[i].addr, vt[i].wdata, rd, er, w);
      chk($sformatf("vec%0d_waits", i), 32'(w), 32'd0);
      chk($sformatf("vec%0d_prdata", i), rd, vt[i].rdata);
      chk($sformatf("vec%0d_pslverr", i), 32'(er), 32'(vt[i].err));
    end

    xfer(1, 1, 32'h3C, 32'h12345678, rd, er, w);
    chk("w3_write_waits", 32'(w), 32'd3);
    chk("w3_write_err", 32'(er), 32'd0);
    xfer(1, 0, 32'h3C, 32'h0, rd, er, w);
    chk("w3_read_waits", 32'(w), 32'd3);
    chk("w3_read_data", rd, 32'h12345678);
    xfer(1, 0, 32'h04, 32'h0, rd, er, w);
    chk("w3_read_other", rd, 32'h0);

    xfer(2, 1, 32'h08, 32'hCAFE0000, rd, er, w);
    chk("w2_write_waits", 32'(w), 32'd2);

    psel = 3'b100;
    PENABLE = 1'b0;
    PADDR = 32'h08;
    PWRITE = 1'b1;
    PWDATA = 32'h55;
    @(posedge HCLK); #1;
    PENABLE = 1'b1;
    @(negedge HCLK);
    chk("abort_wait1_pready", 32'(pready[2]), 32'd0);
    @(posedge HCLK); #1;
    psel = '0;
    PENABLE = 1'b0;
    @(negedge HCLK);
    chk("abort_pready", 32'(pready[2]), 32'd0);
    chk("abort_pslverr", 32'(pslverr[2]), 32'd0);
    @(posedge HCLK); #1;
    xfer(2, 0, 32'h08, 32'h0, rd, er, w);
    chk("abort_reg_kept", rd, 32'hCAFE0000);
    chk("abort_then_read_waits", 32'(w), 32'd2);
    xfer(2, 0, 32'h00, 32'h0, rd, er, w);
    chk("w2_read_id", rd, ID);

    psel = 3'b100;
    PENABLE = 1'b0;
    PADDR = 32'h0C;
    PWRITE = 1'b1;
    PWDATA = 32'h77;
    @(posedge HCLK); #1;
    PENABLE = 1'b1;
    @(negedge HCLK);
    #2;
    HRESETn = 1'b0;
    #1;
    for (int d = 0; d < 3; d++) begin
      chk("midrst_pready", 32'(pready[d]), 32'd0);
      chk("midrst_prdata", prdata[d], 32'd0);
    end
    @(posedge HCLK); #1;
    psel = '0;
    PENABLE = 1'b0;
    @(posedge HCLK); #1;
    HRESETn = 1'b1;
    @(posedge HCLK); #1;

    xfer(0, 0, 32'h04, 32'h0, rd, er, w);
    chk("postrst_u0_04", rd, 32'h0);
    xfer(0, 0, 32'h3C, 32'h0, rd, er, w);
    chk("postrst_u0_3c", rd, 32'h0);
    xfer(1, 0, 32'h3C, 32'h0, rd, er, w);
    chk("postrst_u3_3c", rd, 32'h0);
    xfer(2, 0, 32'h08, 32'h0, rd, er, w);
    chk("postrst_u2_08", rd, 32'h0);
    xfer(2, 0, 32'h0C, 32'h0, rd, er, w);
    chk("postrst_u2_0c", rd, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
